// File: rtl/find_max_loader_pkg.sv
// Shared types and constants for the find-max front-end loader.
// Imported by the loader top and by its operand array.
package find_max_loader_pkg;

  localparam int DEPTH           = 8;
  localparam int ADDR_W          = 3;
  localparam int TCNT_W          = 7;
  localparam int DEFAULT_TIMEOUT = 64;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_RESULT
  } state_t;

endpackage

// File: rtl/find_max_loader_operand_array.sv
// 8-entry operand register file: one synchronous write port and one
// asynchronous read port that the find-max controller addresses directly.
module operand_array
  import find_max_loader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: every entry is reset because the controller may read any address
  // before the first full load, and that read must return a defined 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/find_max_loader.sv
// Front end of the find-max unit: loads eight operands, starts the
// controller, and holds the reported maximum/index behind a valid/ready port.
module find_max_loader
  import find_max_loader_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              start,
  input  logic              completed,
  input  logic              A_R0,
  input  logic              A_R1,
  input  logic              A_R2,
  output logic [WIDTH-1:0]  rd_data,
  input  logic [WIDTH-1:0]  max_in,
  input  logic [ADDR_W-1:0] max_i_in,
  output logic              res_valid,
  output logic [WIDTH-1:0]  res_max,
  output logic [ADDR_W-1:0] res_idx,
  input  logic              res_ready,
  output logic              err
);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wptr;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_in_ready;
  logic                r_start;
  logic                r_res_valid;
  logic [WIDTH-1:0]    r_res_max;
  logic [ADDR_W-1:0]   r_res_idx;
  logic                r_err;

  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_rd_addr;

  // r_in_ready is high exactly in LOAD, so it doubles as the write qualifier.
  assign w_wr_en   = in_valid && r_in_ready;
  assign w_rd_addr = {A_R2, A_R1, A_R0};

  operand_array #(
    .WIDTH(WIDTH)
  ) u_operand_array (
    .clk      (clk),
    .rst      (rst),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_wptr),
    .i_wr_data(in_data),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(rd_data)
  );

  // NOTE: state and handshake flags move together in one block with <=, so
  // every output is a flop and always agrees with the state it decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_wptr      <= '0;
      r_tcnt      <= '0;
      r_in_ready  <= 1'b1;
      r_start     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_max   <= '0;
      r_res_idx   <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (in_valid) begin
            r_wptr <= r_wptr + ADDR_W'(1);
            if (r_wptr == LAST_ADDR) begin
              r_state    <= ST_START;
              r_in_ready <= 1'b0;
              r_start    <= 1'b1;
            end
          end
        end
        ST_START: begin
          r_state <= ST_WAIT;
          r_start <= 1'b0;
        end
        ST_WAIT: begin
          if (completed) begin
            r_res_max   <= max_in;
            r_res_idx   <= max_i_in;
            r_tcnt      <= '0;
            r_state     <= ST_RESULT;
            r_res_valid <= 1'b1;
          end else if (r_tcnt == TCNT_LAST) begin
            // Controller never answered: abandon the run without a result.
            r_err      <= 1'b1;
            r_tcnt     <= '0;
            r_state    <= ST_LOAD;
            r_in_ready <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            r_state     <= ST_LOAD;
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_LOAD;
          r_in_ready  <= 1'b1;
          r_start     <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign start     = r_start;
  assign res_valid = r_res_valid;
  assign res_max   = r_res_max;
  assign res_idx   = r_res_idx;
  assign err       = r_err;

endmodule
